// File: rtl/divider.sv
// rtl/divider.sv - 32-bit sequential radix-2 restoring divider, signed or unsigned
// Optional DIV_ZERO_FAST_EN: a zero divisor bypasses the 32 CALC steps.
module divider (
  input  logic        div_clk,
  input  logic        reset,
  input  logic        div_en,
  input  logic        div_signed,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] s,
  output logic [31:0] r,
  output logic        div_busy,
  output logic        div_done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] dvd;     // dividend shifting out, quotient shifting in
  logic [31:0] dsr;     // divisor magnitude
  logic [31:0] rem;
  logic [31:0] x_orig;
  logic [4:0]  cnt;
  logic        sign_q, sign_r;

  logic [31:0] x_mag, y_mag;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        ge;

  always_comb begin
    x_mag   = (div_signed && x[31]) ? -x : x;
    y_mag   = (div_signed && y[31]) ? -y : y;
    shifted = {rem, dvd[31]};
    ge      = (shifted >= {1'b0, dsr});
    // when ge holds the true difference is below dsr, so 32 bits suffice
    diff    = shifted[31:0] - dsr;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (div_en) begin
`ifdef DIV_ZERO_FAST_EN
          state_nx = (y == 32'd0) ? FIX : CALC;
`else
          state_nx = CALC;
`endif
        end
      end
      CALC:    if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge div_clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      x_orig <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      s      <= '0;
      r      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (div_en) begin
            dvd    <= x_mag;
            dsr    <= y_mag;
            x_orig <= x;
            sign_q <= div_signed & (x[31] ^ y[31]);
            sign_r <= div_signed & x[31];
            rem    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (ge) begin
            rem <= diff;
            dvd <= {dvd[30:0], 1'b1};
          end else begin
            rem <= shifted[31:0];
            dvd <= {dvd[30:0], 1'b0};
          end
        end
        FIX: begin
          // zero divisor returns all-ones and the untouched dividend in both modes
          if (dsr == 32'd0) begin
            s <= 32'hFFFF_FFFF;
            r <= x_orig;
          end else begin
            s <= sign_q ? -dvd : dvd;
            r <= sign_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_busy = (state != IDLE);
  assign div_done = (state == DONE);

endmodule
